// File: rtl/cpu_pkg.sv
// Shared definitions for the parametrised multi-cycle teaching CPU.
package cpu_pkg;

  localparam logic [3:0] OP_MOV  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_LDI  = 4'd7;
  localparam logic [3:0] OP_ADDI = 4'd8;
  localparam logic [3:0] OP_JMP  = 4'd9;
  localparam logic [3:0] OP_JZ   = 4'd10;
  localparam logic [3:0] OP_JNZ  = 4'd11;
  localparam logic [3:0] OP_HLT  = 4'd15;

  typedef enum logic [2:0] {
    ST_FT,
    ST_DC,
    ST_EX,
    ST_WB,
    ST_HALT
  } state_t;

  // Opcodes 0..8 are exactly the ones that write ra.
  function automatic logic op_writes(input logic [3:0] op);
    return (op <= OP_ADDI);
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Register file: two read ports latched on i_rd_en, one write port, one async debug read.
module cpu_regfile #(
  parameter int DW   = 16,
  parameter int RA_W = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_rd_en,
  input  logic [RA_W-1:0] i_ra_addr,
  input  logic [RA_W-1:0] i_rb_addr,
  output logic [DW-1:0]   o_a_data,
  output logic [DW-1:0]   o_b_data,
  input  logic            i_we,
  input  logic [RA_W-1:0] i_wr_addr,
  input  logic [DW-1:0]   i_wr_data,
  input  logic [RA_W-1:0] i_dbg_sel,
  output logic [DW-1:0]   o_dbg_data
);

  localparam int NREG = 2 ** RA_W;

  logic [DW-1:0] r_regs [NREG];
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;

  // Register array write and operand latching; everything clears on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_a <= '0;
      r_b <= '0;
    end else begin
      if (i_we) begin
        r_regs[i_wr_addr] <= i_wr_data;
      end
      if (i_rd_en) begin
        r_a <= r_regs[i_ra_addr];
        r_b <= r_regs[i_rb_addr];
      end
    end
  end

  assign o_a_data   = r_a;
  assign o_b_data   = r_b;
  assign o_dbg_data = r_regs[i_dbg_sel];

endmodule

// File: rtl/cpu_core_param.sv
// Multi-cycle FETCH/DECODE/EXEC/WB core with stalling instruction fetch and sticky HALT.
module cpu_core_param
  import cpu_pkg::*;
#(
  parameter int  DW    = 16,
  parameter int  RA_W  = 3,
  parameter int  IMM_W = 8,
  localparam int IW    = 4 + RA_W + IMM_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  output logic             imem_req,
  output logic [IMM_W-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [IW-1:0]    imem_data,
  output logic [3:0]       phase,
  output logic [IMM_W-1:0] pc,
  output logic [IW-1:0]    instr,
  output logic             wb_en,
  output logic [RA_W-1:0]  wb_addr,
  output logic [DW-1:0]    wb_data,
  output logic             halted,
  input  logic [RA_W-1:0]  dbg_sel,
  output logic [DW-1:0]    dbg_data
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IMM_W-1:0] r_pc;
  logic [IW-1:0]    r_instr;
  logic             r_req_pend;
  logic [DW-1:0]    r_res;

  logic [3:0]       w_op;
  logic [RA_W-1:0]  w_ra;
  logic [RA_W-1:0]  w_rb;
  logic [IMM_W-1:0] w_imm;
  logic [DW-1:0]    w_immz;
  logic [DW-1:0]    w_a;
  logic [DW-1:0]    w_b;
  logic [DW-1:0]    w_alu;
  logic             w_take;
  logic             w_fire;

  assign w_op   = r_instr[IW-1 -: 4];
  assign w_ra   = r_instr[IMM_W +: RA_W];
  assign w_imm  = r_instr[IMM_W-1:0];
  assign w_rb   = w_imm[IMM_W-1 -: RA_W];
  assign w_immz = DW'(w_imm);
  assign w_fire = imem_req && imem_ack;

  cpu_regfile #(
    .DW   (DW),
    .RA_W (RA_W)
  ) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .i_rd_en    (r_state == ST_DC),
    .i_ra_addr  (w_ra),
    .i_rb_addr  (w_rb),
    .o_a_data   (w_a),
    .o_b_data   (w_b),
    .i_we       (wb_en),
    .i_wr_addr  (w_ra),
    .i_wr_data  (r_res),
    .i_dbg_sel  (dbg_sel),
    .o_dbg_data (dbg_data)
  );

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_FT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: fetch stalls until the handshake completes; HLT leaves WB for HALT.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_FT:   w_state_nxt = w_fire ? ST_DC : ST_FT;
      ST_DC:   w_state_nxt = ST_EX;
      ST_EX:   w_state_nxt = ST_WB;
      ST_WB:   w_state_nxt = (w_op == OP_HLT) ? ST_HALT : ST_FT;
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_FT;
    endcase
  end

  // Outputs decoded from state; a pending request outlives a dropped run.
  always_comb begin
    imem_req = 1'b0;
    phase    = 4'b0000;
    halted   = 1'b0;
    wb_en    = 1'b0;
    unique case (r_state)
      ST_FT: begin
        phase    = 4'b0001;
        imem_req = run || r_req_pend;
      end
      ST_DC:   phase = 4'b0010;
      ST_EX:   phase = 4'b0100;
      ST_WB: begin
        phase = 4'b1000;
        wb_en = op_writes(w_op);
      end
      ST_HALT: halted = 1'b1;
      default: phase = 4'b0000;
    endcase
  end

  // ALU result and branch decision, both from the operands latched in DECODE.
  always_comb begin
    w_alu  = '0;
    w_take = 1'b0;
    case (w_op)
      OP_MOV:  w_alu = w_b;
      OP_ADD:  w_alu = w_a + w_b;
      OP_SUB:  w_alu = w_a - w_b;
      OP_AND:  w_alu = w_a & w_b;
      OP_OR:   w_alu = w_a | w_b;
      OP_SHL:  w_alu = {w_a[DW-2:0], 1'b0};
      OP_SHR:  w_alu = {1'b0, w_a[DW-1:1]};
      OP_LDI:  w_alu = w_immz;
      OP_ADDI: w_alu = w_a + w_immz;
      OP_JMP:  w_take = 1'b1;
      OP_JZ:   w_take = (w_a == '0);
      OP_JNZ:  w_take = (w_a != '0);
      default: w_alu = '0;
    endcase
  end

  // PC, instruction latch, request-pending flag and EXEC result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= '0;
      r_instr    <= '0;
      r_req_pend <= 1'b0;
      r_res      <= '0;
    end else begin
      r_req_pend <= imem_req && !imem_ack;
      if (w_fire) begin
        r_instr <= imem_data;
        r_pc    <= r_pc + {{(IMM_W-1){1'b0}}, 1'b1};
      end
      if (r_state == ST_EX) begin
        r_res <= w_alu;
        if (w_take) begin
          r_pc <= w_imm;
        end
      end
    end
  end

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign instr     = r_instr;
  assign wb_addr   = w_ra;
  assign wb_data   = r_res;

endmodule

// File: tb/tb_cpu_core_param.sv
// Directed bench: a DW=16 and a DW=8 core run the same ROM in lock-step.
module tb_cpu_core_param;
  import cpu_pkg::*;

  localparam int IW = 15;

  logic          clk;
  logic          reset;
  logic          run;
  logic          ack;
  logic [1:0]    ack_mode;  // 0: always, 1: every 3rd cycle, 2: never
  logic [2:0]    dbg_sel;
  logic [IW-1:0] rom [256];
  int            cyc;

  logic          req16, wb_en16, halted16;
  logic [7:0]    addr16, pc16;
  logic [IW-1:0] data16, instr16;
  logic [3:0]    phase16;
  logic [2:0]    wb_addr16;
  logic [15:0]   wb_data16, dbg16;

  logic          req8, wb_en8, halted8;
  logic [7:0]    addr8, pc8;
  logic [IW-1:0] data8, instr8;
  logic [3:0]    phase8;
  logic [2:0]    wb_addr8;
  logic [7:0]    wb_data8, dbg8;

  int n_tests = 0;
  int n_fail  = 0;

  logic       mon_en = 1'b0;
  logic       prev_req = 1'b0;
  logic       prev_ack = 1'b0;
  logic [7:0] prev_addr = '0;
  int         stab_cnt = 0;
  int         stab_bad = 0;
  int         sub_cnt = 0;

  cpu_core_param #(.DW(16), .RA_W(3), .IMM_W(8)) dut16 (
    .clk(clk), .reset(reset), .run(run), .imem_req(req16), .imem_addr(addr16),
    .imem_ack(ack), .imem_data(data16), .phase(phase16), .pc(pc16), .instr(instr16),
    .wb_en(wb_en16), .wb_addr(wb_addr16), .wb_data(wb_data16), .halted(halted16),
    .dbg_sel(dbg_sel), .dbg_data(dbg16)
  );

  cpu_core_param #(.DW(8), .RA_W(3), .IMM_W(8)) dut8 (
    .clk(clk), .reset(reset), .run(run), .imem_req(req8), .imem_addr(addr8),
    .imem_ack(ack), .imem_data(data8), .phase(phase8), .pc(pc8), .instr(instr8),
    .wb_en(wb_en8), .wb_addr(wb_addr8), .wb_data(wb_data8), .halted(halted8),
    .dbg_sel(dbg_sel), .dbg_data(dbg8)
  );

  assign data16 = rom[addr16];
  assign data8  = rom[addr8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle count since run was raised; cycle 1 has cyc == 0.
  always @(posedge clk) begin
    if (!run) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  always_comb begin
    ack = 1'b0;
    if (ack_mode == 2'd0)      ack = 1'b1;
    else if (ack_mode == 2'd1) ack = (cyc % 3 == 2);
  end

  // Stalled request must stay asserted with a stable address.
  always @(negedge clk) begin
    if (mon_en && prev_req && !prev_ack) begin
      stab_cnt++;
      if (!(req16 === 1'b1 && addr16 === prev_addr)) stab_bad++;
    end
    prev_req  = req16;
    prev_ack  = ack;
    prev_addr = addr16;
  end

  // Count accepted fetches of address 2 (the SUB of the loop program).
  always @(negedge clk) begin
    if (reset) sub_cnt = 0;
    else if (req16 && ack && addr16 == 8'd2) sub_cnt++;
  end

  function automatic logic [IW-1:0] ins(input logic [3:0] op, input logic [2:0] ra,
                                        input logic [7:0] imm);
    return {op, ra, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_hlt();
    for (int i = 0; i < 256; i++) rom[i] = ins(OP_HLT, 3'd0, 8'd0);
  endtask

  task automatic load_add_prog();
    fill_hlt();
    rom[0] = ins(OP_LDI, 3'd1, 8'd5);
    rom[1] = ins(OP_LDI, 3'd2, 8'd3);
    rom[2] = ins(OP_ADD, 3'd1, 8'h40);  // rb = r2
    rom[3] = ins(OP_HLT, 3'd0, 8'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    run      = 1'b0;
    ack_mode = 2'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic rd(input logic [2:0] sel, output logic [15:0] v16, output logic [7:0] v8);
    dbg_sel = sel;
    #1;
    v16 = dbg16;
    v8  = dbg8;
  endtask

  task automatic wait_halt(input int budget, input string tag);
    int k;
    k = 0;
    while (halted16 !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, {31'd0, halted16}, 32'd1);
  endtask

  logic [15:0] v16;
  logic [7:0]  v8;
  int          hi_cnt;

  initial begin
    reset    = 1'b1;
    run      = 1'b0;
    ack_mode = 2'd0;
    dbg_sel  = '0;
    load_add_prog();

    // 1: reset values, then straight-line program with immediate acks
    repeat (2) @(negedge clk);
    chk("rst_phase", phase16, 4'b0001);
    chk("rst_pc", pc16, 0);
    chk("rst_instr", instr16, 0);
    chk("rst_req", req16, 0);
    chk("rst_wb_en", wb_en16, 0);
    chk("rst_halted", halted16, 0);
    rd(3'd1, v16, v8);
    chk("rst_r1", v16, 0);
    reset = 1'b0;
    @(negedge clk);
    run = 1'b1;
    repeat (11) @(negedge clk);
    rd(3'd1, v16, v8);
    chk("t1_r1_before_add", v16, 5);
    @(negedge clk);
    rd(3'd1, v16, v8);
    chk("t1_r1_after_add", v16, 8);
    repeat (3) @(negedge clk);
    chk("t1_not_halted_c15", halted16, 0);
    @(negedge clk);
    chk("t1_halted_c16", halted16, 1);
    chk("t1_pc", pc16, 4);
    chk("t1_phase_halt", phase16, 4'b0000);
    chk("t1_req_halt", req16, 0);
    rd(3'd2, v16, v8);
    chk("t1_r2", v16, 3);
    chk("t1_r2_dw8", v8, 3);

    // 2: same program, ack every third cycle
    do_reset();
    ack_mode = 2'd1;
    mon_en   = 1'b1;
    run      = 1'b1;
    repeat (23) @(negedge clk);
    chk("t2_not_halted_c23", halted16, 0);
    @(negedge clk);
    chk("t2_halted_c24", halted16, 1);
    mon_en = 1'b0;
    rd(3'd1, v16, v8);
    chk("t2_r1", v16, 8);
    chk("t2_stall_seen", {31'd0, stab_cnt > 0}, 1);
    chk("t2_req_stable", stab_bad, 0);

    // 3: count-down loop
    do_reset();
    fill_hlt();
    rom[0] = ins(OP_LDI, 3'd0, 8'd3);
    rom[1] = ins(OP_LDI, 3'd1, 8'd1);
    rom[2] = ins(OP_SUB, 3'd0, 8'h20);  // rb = r1
    rom[3] = ins(OP_JNZ, 3'd0, 8'd2);
    rom[4] = ins(OP_HLT, 3'd0, 8'd0);
    run = 1'b1;
    wait_halt(200, "t3_halt_timeout");
    rd(3'd0, v16, v8);
    chk("t3_r0", v16, 0);
    chk("t3_sub_count", sub_cnt, 3);
    chk("t3_pc", pc16, 5);

    // 4: 8-bit wrap, logical shift, jump to the last address
    do_reset();
    fill_hlt();
    rom[0] = ins(OP_LDI, 3'd3, 8'd255);
    rom[1] = ins(OP_ADDI, 3'd3, 8'd2);
    rom[2] = ins(OP_SHR, 3'd3, 8'd0);
    rom[3] = ins(OP_JMP, 3'd0, 8'd255);
    run = 1'b1;
    repeat (8) @(negedge clk);
    rd(3'd3, v16, v8);
    chk("t4_addi_dw8", v8, 1);
    chk("t4_addi_dw16", v16, 257);
    wait_halt(100, "t4_halt_timeout");
    rd(3'd3, v16, v8);
    chk("t4_shr_dw8", v8, 0);
    chk("t4_shr_dw16", v16, 128);
    chk("t4_pc_wrap_dw8", pc8, 0);
    chk("t4_pc_wrap_dw16", pc16, 0);
    chk("t4_halted_dw8", halted8, 1);

    // 5a: reset during EXEC of ADD
    do_reset();
    load_add_prog();
    run = 1'b1;
    hi_cnt = 0;
    while (!(phase16 === 4'b0100 && instr16[14:11] === OP_ADD) && hi_cnt < 40) begin
      @(negedge clk);
      hi_cnt++;
    end
    chk("t5_reached_add_ex", {31'd0, hi_cnt < 40}, 1);
    reset = 1'b1;
    #1;
    chk("t5_ex_wb_en", wb_en16, 0);
    chk("t5_ex_phase", phase16, 4'b0001);
    chk("t5_ex_pc", pc16, 0);
    chk("t5_ex_instr", instr16, 0);
    rd(3'd1, v16, v8);
    chk("t5_ex_r1", v16, 0);
    repeat (2) @(negedge clk);
    chk("t5_ex_wb_en_held", wb_en16, 0);

    // 5b: request pending, run dropped, then reset
    reset    = 1'b0;
    ack_mode = 2'd2;
    run      = 1'b1;
    @(negedge clk);
    chk("t5_req_up", req16, 1);
    run = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_req_held_norun", req16, 1);
    chk("t5_still_fetch", phase16, 4'b0001);
    reset = 1'b1;
    #1;
    chk("t5_req_abandoned", req16, 0);
    chk("t5_halted_rst", halted16, 0);

    // 6: idle without run, then start fetching from 0
    @(negedge clk);
    reset    = 1'b0;
    ack_mode = 2'd0;
    hi_cnt   = 0;
    repeat (20) begin
      @(negedge clk);
      if (req16 !== 1'b0) hi_cnt++;
    end
    chk("t6_idle_no_req", hi_cnt, 0);
    chk("t6_idle_pc", pc16, 0);
    run = 1'b1;
    #1;
    chk("t6_req_on_run", req16, 1);
    chk("t6_addr0", addr16, 0);
    @(negedge clk);
    chk("t6_phase_dc", phase16, 4'b0010);
    chk("t6_pc1", pc16, 1);
    chk("t6_instr", instr16, {OP_LDI, 3'd1, 8'd5});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
